// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath/memory.
// master = controller (drives selects/strobes), slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ready;
  logic [5:0]  alu_selection;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        illegal;
  logic        bus_error;
  logic [2:0]  state;
  logic [31:0] retired;

  modport master (
    input  instr, alu_zero, mem_ready,
    output alu_selection, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
           ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
           illegal, bus_error, state, retired
  );

  modport slave (
    output instr, alu_zero, mem_ready,
    input  alu_selection, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
           ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
           illegal, bus_error, state, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with memory ready handshake,
// illegal-instruction and memory-timeout traps, retired-instruction counter.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 0
) (
  input logic                  clk,
  input logic                  rst,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t        state_q, state_d;
  logic [TW-1:0] wait_q;
  logic          illegal_q, bus_error_q;
  logic [31:0]   retired_q;
  logic          set_illegal, set_bus_error, retire, timeout;

  logic [5:0] opcode, funct;
  logic       is_r, is_addi, is_andi, is_lw, is_sw, is_beq, is_j, funct_ok, legal;
  logic       unused_instr_bits;

  assign opcode = bus.instr[31:26];
  assign funct  = bus.instr[5:0];
  assign unused_instr_bits = ^bus.instr[25:6];

  assign is_r    = (opcode == 6'b000000);
  assign is_addi = (opcode == 6'b001000);
  assign is_andi = (opcode == 6'b001100);
  assign is_lw   = (opcode == 6'b100011);
  assign is_sw   = (opcode == 6'b101011);
  assign is_beq  = (opcode == 6'b000100);
  assign is_j    = (opcode == 6'b000010);

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100111, 6'b101010, 6'b100110: funct_ok = 1'b1;
      default:                         funct_ok = 1'b0;
    endcase
  end

  assign legal = (is_r & funct_ok) | is_addi | is_andi | is_lw | is_sw | is_beq | is_j;

  // The wait counter tracks cycles spent in the current FETCH/MEM visit; the last
  // allowed cycle times out only if memory has not answered in that same cycle.
  assign timeout = (MEM_TIMEOUT != 0) && (wait_q == TLIM) && !bus.mem_ready;

  always_comb begin
    state_d           = state_q;
    set_illegal       = 1'b0;
    set_bus_error     = 1'b0;
    retire            = 1'b0;
    bus.alu_selection = 6'b100000;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_src        = 2'b00;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;

    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = DECODE;
        end else if (timeout) begin
          state_d       = TRAP;
          set_bus_error = 1'b1;
        end
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        if (legal) begin
          state_d = EXEC;
        end else begin
          state_d     = TRAP;
          set_illegal = 1'b1;
        end
      end
      EXEC: begin
        if (is_r) begin
          bus.alu_src_a     = 1'b1;
          bus.alu_selection = funct;
          state_d           = WB;
        end else if (is_addi || is_andi || is_lw || is_sw) begin
          bus.alu_src_a     = 1'b1;
          bus.alu_src_b     = 2'b10;
          bus.alu_selection = opcode;
          state_d           = (is_lw || is_sw) ? MEM : WB;
        end else if (is_beq) begin
          bus.alu_src_a     = 1'b1;
          bus.alu_selection = 6'b000100;
          if (!bus.alu_zero) begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'b01;
          end
          state_d = FETCH;
          retire  = 1'b1;
        end else if (is_j) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'b10;
          state_d      = FETCH;
          retire       = 1'b1;
        end else begin
          state_d     = TRAP;
          set_illegal = 1'b1;
        end
      end
      MEM: begin
        bus.i_or_d    = 1'b1;
        bus.mem_read  = is_lw;
        bus.mem_write = is_sw;
        if (bus.mem_ready) begin
          state_d = is_sw ? FETCH : WB;
          retire  = is_sw;
        end else if (timeout) begin
          state_d       = TRAP;
          set_bus_error = 1'b1;
        end
      end
      WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = is_r;
        bus.mem_to_reg = is_lw;
        state_d        = FETCH;
        retire         = 1'b1;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase

    // Reset has priority over whatever the current state would request.
    if (rst) begin
      bus.alu_selection = 6'b100000;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_src        = 2'b00;
      bus.reg_write     = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.mem_to_reg    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
      retired_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || MEM_TIMEOUT == 0) wait_q <= '0;
      else                                        wait_q <= wait_q + 1'b1;
      if (set_illegal)   illegal_q   <= 1'b1;
      if (set_bus_error) bus_error_q <= 1'b1;
      if (retire)        retired_q   <= retired_q + 32'd1;
    end
  end

  assign bus.state     = state_q;
  assign bus.illegal   = illegal_q & ~rst;
  assign bus.bus_error = bus_error_q & ~rst;
  assign bus.retired   = rst ? 32'd0 : retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: directed per-cycle vectors push expected outputs, monitors compare at negedge.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if b0 ();
  mips_multicycle_ctrl_if b1 ();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(0)) dut0 (.clk(clk), .rst(rst0), .bus(b0));
  mips_multicycle_ctrl #(.MEM_TIMEOUT(5)) dut1 (.clk(clk), .rst(rst1), .bus(b1));

  typedef struct packed {
    logic [2:0]  st;
    logic [5:0]  sel;
    logic [12:0] ctl;
    logic        ill;
    logic        be;
    logic [31:0] ret;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  // {src_a, src_b, i_or_d, mem_read, mem_write, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg}
  localparam logic [12:0] C_Z   = 13'b0_00_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] C_FW  = 13'b0_01_0_1_0_0_0_00_0_0_0;
  localparam logic [12:0] C_FG  = 13'b0_01_0_1_0_1_1_00_0_0_0;
  localparam logic [12:0] C_DEC = 13'b0_11_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] C_EXR = 13'b1_00_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] C_EXI = 13'b1_10_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] C_BT  = 13'b1_00_0_0_0_0_1_01_0_0_0;
  localparam logic [12:0] C_J   = 13'b0_00_0_0_0_0_1_10_0_0_0;
  localparam logic [12:0] C_MRD = 13'b0_00_1_1_0_0_0_00_0_0_0;
  localparam logic [12:0] C_MWR = 13'b0_00_1_0_1_0_0_00_0_0_0;
  localparam logic [12:0] C_WBR = 13'b0_00_0_0_0_0_0_00_1_1_0;
  localparam logic [12:0] C_WBL = 13'b0_00_0_0_0_0_0_00_1_0_1;
  localparam logic [12:0] C_WBI = 13'b0_00_0_0_0_0_0_00_1_0_0;
  localparam logic [5:0]  SADD  = 6'b100000;

  localparam logic [31:0] ADD  = 32'h00221820;
  localparam logic [31:0] SUB  = 32'h00221822;
  localparam logic [31:0] LW   = 32'h8C220004;
  localparam logic [31:0] SW   = 32'hAC220004;
  localparam logic [31:0] BEQ  = 32'h10220003;
  localparam logic [31:0] JMP  = 32'h08000010;
  localparam logic [31:0] ADDI = 32'h20220005;
  localparam logic [31:0] ANDI = 32'h30220005;
  localparam logic [31:0] BADO = 32'hFC000000;
  localparam logic [31:0] BADF = 32'h00221821;

  task automatic chk(input int d, input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL dut%0d %s: got %h expected %h at %0t", d, nm, got, want, $time);
    end
  endtask

  task automatic compare(input int d, input exp_t e, input logic [2:0] st, input logic [5:0] sel,
                         input logic [12:0] ctl, input logic ill, input logic be, input logic [31:0] ret);
    chk(d, "state", 32'(st), 32'(e.st));
    chk(d, "alu_selection", 32'(sel), 32'(e.sel));
    chk(d, "controls", 32'(ctl), 32'(e.ctl));
    chk(d, "illegal/bus_error", 32'({ill, be}), 32'({e.ill, e.be}));
    chk(d, "retired", ret, e.ret);
  endtask

  // One clock cycle of stimulus plus the outputs expected during that cycle.
  task automatic step(input int d, input logic r, input logic mr, input logic az, input logic [31:0] ins,
                      input logic [2:0] st, input logic [5:0] sel, input logic [12:0] ctl,
                      input logic ill, input logic be, input logic [31:0] ret);
    exp_t e;
    e.st = st; e.sel = sel; e.ctl = ctl; e.ill = ill; e.be = be; e.ret = ret;
    if (d == 0) begin
      rst0 = r; b0.mem_ready = mr; b0.alu_zero = az; b0.instr = ins;
      q0.push_back(e);
    end else begin
      rst1 = r; b1.mem_ready = mr; b1.alu_zero = az; b1.instr = ins;
      q1.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : mon0
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare(0, e, b0.state, b0.alu_selection,
                {b0.alu_src_a, b0.alu_src_b, b0.i_or_d, b0.mem_read, b0.mem_write, b0.ir_write,
                 b0.pc_write, b0.pc_src, b0.reg_write, b0.reg_dst, b0.mem_to_reg},
                b0.illegal, b0.bus_error, b0.retired);
      end
    end
  end

  initial begin : mon1
    exp_t e;
    forever begin
      @(negedge clk);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare(1, e, b1.state, b1.alu_selection,
                {b1.alu_src_a, b1.alu_src_b, b1.i_or_d, b1.mem_read, b1.mem_write, b1.ir_write,
                 b1.pc_write, b1.pc_src, b1.reg_write, b1.reg_dst, b1.mem_to_reg},
                b1.illegal, b1.bus_error, b1.retired);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not complete within 50000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst0 = 1'b1; rst1 = 1'b1;
    b0.instr = ADD; b0.alu_zero = 1'b0; b0.mem_ready = 1'b0;
    b1.instr = ADD; b1.alu_zero = 1'b0; b1.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset state (rst still high, state register already reset)
    step(0, 1, 1, 0, ADD, 3'd0, SADD, C_Z, 0, 0, 0);
    // add: FETCH, DECODE, EXEC, WB
    step(0, 0, 1, 0, ADD, 3'd0, SADD, C_FG, 0, 0, 0);
    step(0, 0, 0, 0, ADD, 3'd1, SADD, C_DEC, 0, 0, 0);
    step(0, 0, 0, 0, ADD, 3'd2, 6'b100000, C_EXR, 0, 0, 0);
    step(0, 0, 0, 0, ADD, 3'd4, SADD, C_WBR, 0, 0, 0);
    // lw with three wait cycles in MEM
    step(0, 0, 1, 0, LW, 3'd0, SADD, C_FG, 0, 0, 1);
    step(0, 0, 0, 0, LW, 3'd1, SADD, C_DEC, 0, 0, 1);
    step(0, 0, 0, 0, LW, 3'd2, 6'b100011, C_EXI, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, LW, 3'd3, SADD, C_MRD, 0, 0, 1);
    step(0, 0, 1, 0, LW, 3'd3, SADD, C_MRD, 0, 0, 1);
    step(0, 0, 0, 0, LW, 3'd4, SADD, C_WBL, 0, 0, 1);
    // beq taken (alu_zero=0) and not taken (alu_zero=1)
    step(0, 0, 1, 0, BEQ, 3'd0, SADD, C_FG, 0, 0, 2);
    step(0, 0, 0, 0, BEQ, 3'd1, SADD, C_DEC, 0, 0, 2);
    step(0, 0, 0, 0, BEQ, 3'd2, 6'b000100, C_BT, 0, 0, 2);
    step(0, 0, 1, 1, BEQ, 3'd0, SADD, C_FG, 0, 0, 3);
    step(0, 0, 0, 1, BEQ, 3'd1, SADD, C_DEC, 0, 0, 3);
    step(0, 0, 0, 1, BEQ, 3'd2, 6'b000100, C_EXR, 0, 0, 3);
    // sw with one FETCH wait cycle, then j
    step(0, 0, 0, 0, SW, 3'd0, SADD, C_FW, 0, 0, 4);
    step(0, 0, 1, 0, SW, 3'd0, SADD, C_FG, 0, 0, 4);
    step(0, 0, 0, 0, SW, 3'd1, SADD, C_DEC, 0, 0, 4);
    step(0, 0, 0, 0, SW, 3'd2, 6'b101011, C_EXI, 0, 0, 4);
    step(0, 0, 1, 0, SW, 3'd3, SADD, C_MWR, 0, 0, 4);
    step(0, 0, 1, 0, JMP, 3'd0, SADD, C_FG, 0, 0, 5);
    step(0, 0, 0, 0, JMP, 3'd1, SADD, C_DEC, 0, 0, 5);
    step(0, 0, 0, 0, JMP, 3'd2, SADD, C_J, 0, 0, 5);
    // addi, andi, sub
    step(0, 0, 1, 0, ADDI, 3'd0, SADD, C_FG, 0, 0, 6);
    step(0, 0, 0, 0, ADDI, 3'd1, SADD, C_DEC, 0, 0, 6);
    step(0, 0, 0, 0, ADDI, 3'd2, 6'b001000, C_EXI, 0, 0, 6);
    step(0, 0, 0, 0, ADDI, 3'd4, SADD, C_WBI, 0, 0, 6);
    step(0, 0, 1, 0, ANDI, 3'd0, SADD, C_FG, 0, 0, 7);
    step(0, 0, 0, 0, ANDI, 3'd1, SADD, C_DEC, 0, 0, 7);
    step(0, 0, 0, 0, ANDI, 3'd2, 6'b001100, C_EXI, 0, 0, 7);
    step(0, 0, 0, 0, ANDI, 3'd4, SADD, C_WBI, 0, 0, 7);
    step(0, 0, 1, 0, SUB, 3'd0, SADD, C_FG, 0, 0, 8);
    step(0, 0, 0, 0, SUB, 3'd1, SADD, C_DEC, 0, 0, 8);
    step(0, 0, 0, 0, SUB, 3'd2, 6'b100010, C_EXR, 0, 0, 8);
    step(0, 0, 0, 0, SUB, 3'd4, SADD, C_WBR, 0, 0, 8);
    // illegal opcode -> TRAP, no further mem_read even with mem_ready high
    step(0, 0, 1, 0, BADO, 3'd0, SADD, C_FG, 0, 0, 9);
    step(0, 0, 1, 0, BADO, 3'd1, SADD, C_DEC, 0, 0, 9);
    step(0, 0, 1, 0, BADO, 3'd5, SADD, C_Z, 1, 0, 9);
    step(0, 0, 1, 0, BADO, 3'd5, SADD, C_Z, 1, 0, 9);
    step(0, 1, 1, 0, BADO, 3'd5, SADD, C_Z, 0, 0, 0);
    // illegal funct
    step(0, 0, 1, 0, BADF, 3'd0, SADD, C_FG, 0, 0, 0);
    step(0, 0, 0, 0, BADF, 3'd1, SADD, C_DEC, 0, 0, 0);
    step(0, 0, 1, 0, BADF, 3'd5, SADD, C_Z, 1, 0, 0);
    step(0, 1, 1, 0, BADF, 3'd5, SADD, C_Z, 0, 0, 0);
    // reset in the middle of an add, then a full add
    step(0, 0, 1, 0, ADD, 3'd0, SADD, C_FG, 0, 0, 0);
    step(0, 0, 0, 0, ADD, 3'd1, SADD, C_DEC, 0, 0, 0);
    step(0, 1, 1, 0, ADD, 3'd2, SADD, C_Z, 0, 0, 0);
    step(0, 0, 1, 0, ADD, 3'd0, SADD, C_FG, 0, 0, 0);
    step(0, 0, 0, 0, ADD, 3'd1, SADD, C_DEC, 0, 0, 0);
    step(0, 0, 0, 0, ADD, 3'd2, 6'b100000, C_EXR, 0, 0, 0);
    step(0, 0, 0, 0, ADD, 3'd4, SADD, C_WBR, 0, 0, 0);
    step(0, 0, 0, 0, ADD, 3'd0, SADD, C_FW, 0, 0, 1);
    rst0 = 1'b1;

    // MEM_TIMEOUT=5: FETCH timeout
    step(1, 1, 0, 0, ADD, 3'd0, SADD, C_Z, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, ADD, 3'd0, SADD, C_FW, 0, 0, 0);
    step(1, 0, 1, 0, ADD, 3'd5, SADD, C_Z, 0, 1, 0);
    step(1, 0, 1, 0, ADD, 3'd5, SADD, C_Z, 0, 1, 0);
    step(1, 1, 0, 0, LW, 3'd5, SADD, C_Z, 0, 0, 0);
    // mem_ready arriving in the fifth cycle wins
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, LW, 3'd0, SADD, C_FW, 0, 0, 0);
    step(1, 0, 1, 0, LW, 3'd0, SADD, C_FG, 0, 0, 0);
    step(1, 0, 0, 0, LW, 3'd1, SADD, C_DEC, 0, 0, 0);
    step(1, 0, 0, 0, LW, 3'd2, 6'b100011, C_EXI, 0, 0, 0);
    // MEM timeout
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, LW, 3'd3, SADD, C_MRD, 0, 0, 0);
    step(1, 0, 1, 0, LW, 3'd5, SADD, C_Z, 0, 1, 0);
    rst1 = 1'b1;

    @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
